// File: rtl/strait_pkg.sv
// Shared constants for the STRAIT systolic-array routing blocks: widths,
// output direction encodings and the input-side mux selects.
package strait_pkg;
   localparam int STRAIT_DATA_W = 32;
   localparam int BEAT_CNT_W    = 16;

   localparam logic DIR_BOTTOM = 1'b1;
   localparam logic DIR_RIGHT  = 1'b0;

   // Input-side mux selects, used by the partner input demux/mux blocks.
   localparam logic [1:0] IN_MUX_WEST  = 2'd0;
   localparam logic [1:0] IN_MUX_NORTH = 2'd1;
   localparam logic [1:0] IN_MUX_ZERO  = 2'd2;
endpackage

// File: rtl/strait_sync_fifo.sv
// Single-clock FIFO with power-of-two depth. The head is read
// combinationally from storage; storage itself is not reset.
module strait_sync_fifo #(
   parameter int DATA_W = 33,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/p_output_demux_strait.sv
// Buffered output demux for a PE partial sum: each beat carries its own
// direction and leaves on exactly one channel, in strict arrival order.
module p_output_demux_strait
   import strait_pkg::*;
#(
   parameter int DATA_W = STRAIT_DATA_W,
   parameter int DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     in_p,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  select,
   output logic [DATA_W-1:0]     to_bottom,
   output logic                  bottom_valid,
   input  logic                  bottom_ready,
   output logic [DATA_W-1:0]     to_right,
   output logic                  right_valid,
   input  logic                  right_ready,
   input  logic                  clear_count,
   output logic [BEAT_CNT_W-1:0] beat_count
);
   logic [DATA_W:0] head;
   logic            head_sel;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            init_q;

   strait_sync_fifo #(
      .DATA_W (DATA_W + 1),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data ({select, in_p}),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   // init_q keeps in_ready low until the first edge out of reset.
   assign in_ready = init_q & ~full;
   assign push     = in_valid & in_ready;

   assign head_sel     = head[DATA_W];
   assign bottom_valid = ~empty & (head_sel == DIR_BOTTOM);
   assign right_valid  = ~empty & (head_sel == DIR_RIGHT);
   assign to_bottom    = bottom_valid ? head[DATA_W-1:0] : '0;
   assign to_right     = right_valid  ? head[DATA_W-1:0] : '0;

   // Only the active channel's ready can release the head.
   assign pop = (bottom_valid & bottom_ready) | (right_valid & right_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_q     <= 1'b0;
         beat_count <= '0;
      end else begin
         init_q <= 1'b1;
         if (clear_count) beat_count <= '0;
         else if (pop)    beat_count <= beat_count + BEAT_CNT_W'(1);
      end
   end
endmodule
